// File: rtl/mem_access_stage_if.sv
// Bus between the EX/MEM register and the data-memory access stage.
// The pipeline side drives the request as master; the memory stage answers as slave.
interface mem_access_stage_if;
   logic        MemRead_in;
   logic        MemWrite_in;
   logic [1:0]  MemSize_in;
   logic        MemSigned_in;
   logic [31:0] Address_in;
   logic [31:0] WriteData_in;
   logic [31:0] ReadData_out;
   logic        Stall_out;
   logic        Fault_out;

   modport master (
      output MemRead_in, MemWrite_in, MemSize_in, MemSigned_in, Address_in, WriteData_in,
      input  ReadData_out, Stall_out, Fault_out
   );

   modport slave (
      input  MemRead_in, MemWrite_in, MemSize_in, MemSigned_in, Address_in, WriteData_in,
      output ReadData_out, Stall_out, Fault_out
   );
endinterface

// File: rtl/mem_access_stage.sv
// Data-memory access stage of the five-stage MIPS pipeline.
// Owns a word-organised data RAM and performs byte/halfword/word loads and
// stores with WAIT_CYCLES wait states, stalling the upstream stages meanwhile.
module mem_access_stage #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 1
) (
   input  logic               clk,
   input  logic               reset,
   mem_access_stage_if.slave  memBus
);

   localparam int ADDR_BITS = $clog2(DEPTH_WORDS);

   // The IDLE acceptance cycle already stalls, so WAIT only has to cover the
   // remaining WAIT_CYCLES-1 cycles before the access edge; with no wait
   // states the access happens on the acceptance edge itself.
   localparam logic [2:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } stateT;

   stateT       state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] readData_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic                 reqValid;
   logic                 reqFaulty;
   logic                 stall;
   logic                 fault;
   logic                 accessEn;
   logic [ADDR_BITS-1:0] wordIdx;
   logic [31:0]          rdWord;
   logic [7:0]           laneByte;
   logic [15:0]          laneHalf;
   logic [31:0]          loadVal;
   logic [31:0]          wrWord;
   logic                 unusedAddrBits;

   assign reqValid = memBus.MemRead_in | memBus.MemWrite_in;
   assign reqFaulty = (memBus.MemRead_in & memBus.MemWrite_in)
                    | (memBus.MemSize_in == 2'b11)
                    | ((memBus.MemSize_in == 2'b01) & memBus.Address_in[0])
                    | ((memBus.MemSize_in == 2'b10) & (memBus.Address_in[1:0] != 2'b00));

   // Upper address bits are deliberately dropped so addresses wrap around the RAM.
   assign wordIdx        = memBus.Address_in[ADDR_BITS+1:2];
   assign unusedAddrBits = ^memBus.Address_in[31:ADDR_BITS+2];
   assign rdWord         = mem[wordIdx];

   // Lane selection, load extension and the read-modify-write merge for stores.
   always_comb begin
      laneByte = rdWord[{memBus.Address_in[1:0], 3'b000} +: 8];
      laneHalf = memBus.Address_in[1] ? rdWord[31:16] : rdWord[15:0];
      loadVal  = rdWord;
      wrWord   = memBus.WriteData_in;
      case (memBus.MemSize_in)
         2'b00: begin
            loadVal = {{24{memBus.MemSigned_in & laneByte[7]}}, laneByte};
            wrWord  = rdWord;
            wrWord[{memBus.Address_in[1:0], 3'b000} +: 8] = memBus.WriteData_in[7:0];
         end
         2'b01: begin
            loadVal = {{16{memBus.MemSigned_in & laneHalf[15]}}, laneHalf};
            wrWord  = rdWord;
            if (memBus.Address_in[1]) begin
               wrWord[31:16] = memBus.WriteData_in[15:0];
            end else begin
               wrWord[15:0] = memBus.WriteData_in[15:0];
            end
         end
         default: begin
            loadVal = rdWord;
            wrWord  = memBus.WriteData_in;
         end
      endcase
   end

   // Next-state, wait counter and the stall/fault/access decisions of the access FSM.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stall    = 1'b0;
      fault    = 1'b0;
      accessEn = 1'b0;
      case (state_q)
         IDLE: begin
            if (reqValid) begin
               if (reqFaulty) begin
                  fault = 1'b1;
               end else begin
                  stall = 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     accessEn = 1'b1;
                     state_d  = DONE;
                  end else begin
                     cnt_d   = CNT_LOAD;
                     state_d = WAIT;
                  end
               end
            end
         end
         WAIT: begin
            stall = 1'b1;
            if (cnt_q == 3'd0) begin
               accessEn = 1'b1;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counter and load result; reset aborts any access in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= 3'd0;
         readData_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accessEn && memBus.MemRead_in) begin
            readData_q <= loadVal;
         end
      end
   end

   // RAM write port; contents survive reset and only change on a store's access edge.
   always_ff @(posedge clk) begin
      if (accessEn && memBus.MemWrite_in) begin
         mem[wordIdx] <= wrWord;
      end
   end

   assign memBus.ReadData_out = readData_q;
   assign memBus.Stall_out    = stall;
   assign memBus.Fault_out    = fault;

endmodule
